// File: rtl/rf_write_queue.sv
// rf_write_queue: in-order write-back buffer in front of the tiny8 register file.
// Takes up to two writes per cycle, drains up to two per cycle, and never aims
// both regfile write ports at the same register (same-register pairs are coalesced
// so only the younger value lands).
module rf_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_rd0,
    input  logic [7:0]              in_data0,
    input  logic [1:0]              in_rd1,
    input  logic [7:0]              in_data1,
    output logic                    rf_load1,
    output logic [1:0]              rf_r1,
    output logic [7:0]              rf_in1,
    output logic                    rf_load2,
    output logic [1:0]              rf_r2,
    output logic [7:0]              rf_in2,
    output logic [3:0]              pending,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    rdMem   [DEPTH];
    logic [7:0]    dataMem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] headNext;
    logic [AW-1:0] slot1;
    logic [AW-1:0] offs;
    logic          fire0;
    logic          fire1;
    logic [1:0]    nEnq;
    logic [1:0]    nDeq;

    // Space for a full pair is judged on the registered count only; a pop in the
    // same cycle does not lend credit to the upstream stage.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
    assign fire0    = in_valid[0] && in_ready;
    assign fire1    = in_valid[1] && in_ready;
    assign slot1    = tail + AW'(fire0);
    assign nEnq     = {1'b0, fire0} + {1'b0, fire1};
    assign headNext = head + AW'(1);

    // Drain decision from the two oldest entries; a same-register pair collapses
    // onto port 1 carrying the younger value, and reset suppresses any write.
    always_comb begin
        rf_load1 = 1'b0;
        rf_r1    = '0;
        rf_in1   = '0;
        rf_load2 = 1'b0;
        rf_r2    = '0;
        rf_in2   = '0;
        nDeq     = 2'd0;
        if (count == CW'(1)) begin
            nDeq     = 2'd1;
            rf_load1 = !rst;
            rf_r1    = rst ? 2'd0 : rdMem[head];
            rf_in1   = rst ? 8'd0 : dataMem[head];
        end else if (count >= CW'(2)) begin
            nDeq = 2'd2;
            if (rdMem[head] == rdMem[headNext]) begin
                rf_load1 = !rst;
                rf_r1    = rst ? 2'd0 : rdMem[headNext];
                rf_in1   = rst ? 8'd0 : dataMem[headNext];
            end else begin
                rf_load1 = !rst;
                rf_r1    = rst ? 2'd0 : rdMem[head];
                rf_in1   = rst ? 8'd0 : dataMem[head];
                rf_load2 = !rst;
                rf_r2    = rst ? 2'd0 : rdMem[headNext];
                rf_in2   = rst ? 8'd0 : dataMem[headNext];
            end
        end
    end

    // Pending mask: every slot sitting between head and head+count marks its register.
    always_comb begin
        pending = '0;
        offs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = AW'(i) - head;
            if (CW'(offs) < count) begin
                pending[rdMem[i]] = 1'b1;
            end
        end
    end

    // Queue state: lane0 lands at tail, lane1 right behind it; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fire0) begin
                rdMem[tail]   <= in_rd0;
                dataMem[tail] <= in_data0;
            end
            if (fire1) begin
                rdMem[slot1]   <= in_rd1;
                dataMem[slot1] <= in_data1;
            end
            head  <= head + AW'(nDeq);
            tail  <= tail + AW'(nEnq);
            count <= count + CW'(nEnq) - CW'(nDeq);
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: self-checking bench for rf_write_queue.
// A second, two-entry instance is used where the queue must actually fill up,
// since a four-entry queue that drains every cycle never holds more than two.
module tb_rf_write_queue;

    logic       clk;
    logic       rst;

    logic [1:0] in_valid;
    logic       in_ready;
    logic [1:0] in_rd0;
    logic [7:0] in_data0;
    logic [1:0] in_rd1;
    logic [7:0] in_data1;
    logic       rf_load1;
    logic [1:0] rf_r1;
    logic [7:0] rf_in1;
    logic       rf_load2;
    logic [1:0] rf_r2;
    logic [7:0] rf_in2;
    logic [3:0] pending;
    logic [2:0] count;

    logic [1:0] s_valid;
    logic       s_ready;
    logic [1:0] s_rd0;
    logic [7:0] s_data0;
    logic [1:0] s_rd1;
    logic [7:0] s_data1;
    logic       s_load1;
    logic [1:0] s_r1;
    logic [7:0] s_in1;
    logic       s_load2;
    logic [1:0] s_r2;
    logic [7:0] s_in2;
    logic [3:0] s_pending;
    logic [1:0] s_count;

    int checks = 0;
    int errors = 0;

    rf_write_queue #(.DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd0(in_rd0), .in_data0(in_data0),
        .in_rd1(in_rd1), .in_data1(in_data1),
        .rf_load1(rf_load1), .rf_r1(rf_r1), .rf_in1(rf_in1),
        .rf_load2(rf_load2), .rf_r2(rf_r2), .rf_in2(rf_in2),
        .pending(pending), .count(count)
    );

    rf_write_queue #(.DEPTH(2)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_rd0(s_rd0), .in_data0(s_data0),
        .in_rd1(s_rd1), .in_data1(s_data1),
        .rf_load1(s_load1), .rf_r1(s_r1), .rf_in1(s_in1),
        .rf_load2(s_load2), .rf_r2(s_r2), .rf_in2(s_in2),
        .pending(s_pending), .count(s_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] r0, input logic [7:0] d0,
                         input logic [1:0] r1, input logic [7:0] d1);
        in_valid = v;
        in_rd0   = r0;
        in_data0 = d0;
        in_rd1   = r1;
        in_data1 = d1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0000", pending); end
        if (rf_load1 !== 1'b0 || rf_load2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_loads: got %b%b expected 00", rf_load1, rf_load2); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
        if (rf_r1 !== 2'd0 || rf_in1 !== 8'd0) begin errors++; $display("[TB] FAIL reset_port1: got %0d/%h expected 0/00", rf_r1, rf_in1); end
        drive(2'b11, 2'd1, 8'h21, 2'd2, 8'h42);
        @(negedge clk);
        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        checks++;
        if (count !== 3'd2) begin errors++; $display("[TB] FAIL reset_prefill: got %0d expected 2", count); end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_load1 !== 1'b0 || rf_load2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cycle_loads: got %b%b expected 00", rf_load1, rf_load2); end
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_flush_count: got %0d expected 0", count); end
        if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flush_pending: got %b expected 0000", pending); end
        if (rf_load1 !== 1'b0 || rf_load2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_loads: got %b%b expected 00", rf_load1, rf_load2); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_flush_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        drive(2'b01, 2'd2, 8'h5A, 2'd0, 8'h00);
        @(negedge clk);
        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        checks += 4;
        if (rf_load1 !== 1'b1 || rf_r1 !== 2'd2 || rf_in1 !== 8'h5A) begin errors++; $display("[TB] FAIL single_port1: got %b/%0d/%h expected 1/2/5a", rf_load1, rf_r1, rf_in1); end
        if (rf_load2 !== 1'b0) begin errors++; $display("[TB] FAIL single_load2: got %b expected 0", rf_load2); end
        if (pending !== 4'b0100) begin errors++; $display("[TB] FAIL single_pending: got %b expected 0100", pending); end
        if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
        @(negedge clk);
        checks += 2;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL single_drained: got %0d expected 0", count); end
        if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL single_pending_clear: got %b expected 0000", pending); end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        drive(2'b11, 2'd0, 8'h11, 2'd3, 8'h33);
        @(negedge clk);
        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        checks += 3;
        if (rf_load1 !== 1'b1 || rf_r1 !== 2'd0 || rf_in1 !== 8'h11) begin errors++; $display("[TB] FAIL dual_port1: got %b/%0d/%h expected 1/0/11", rf_load1, rf_r1, rf_in1); end
        if (rf_load2 !== 1'b1 || rf_r2 !== 2'd3 || rf_in2 !== 8'h33) begin errors++; $display("[TB] FAIL dual_port2: got %b/%0d/%h expected 1/3/33", rf_load2, rf_r2, rf_in2); end
        if (pending !== 4'b1001) begin errors++; $display("[TB] FAIL dual_pending: got %b expected 1001", pending); end
        @(negedge clk);
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL dual_drained: got %0d expected 0", count); end
    endtask

    task automatic test_coalesce();
        @(negedge clk);
        drive(2'b11, 2'd1, 8'hAA, 2'd1, 8'hBB);
        @(negedge clk);
        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        checks += 3;
        if (rf_load1 !== 1'b1 || rf_r1 !== 2'd1 || rf_in1 !== 8'hBB) begin errors++; $display("[TB] FAIL coalesce_port1: got %b/%0d/%h expected 1/1/bb", rf_load1, rf_r1, rf_in1); end
        if (rf_load2 !== 1'b0) begin errors++; $display("[TB] FAIL coalesce_load2: got %b expected 0", rf_load2); end
        if (pending !== 4'b0010) begin errors++; $display("[TB] FAIL coalesce_pending: got %b expected 0010", pending); end
        @(negedge clk);
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL coalesce_drained: got %0d expected 0", count); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_empty: got %b expected 1", s_ready); end
        s_valid = 2'b11; s_rd0 = 2'd0; s_data0 = 8'hA0; s_rd1 = 2'd1; s_data1 = 8'hA1;
        @(negedge clk);
        checks += 4;
        if (s_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_full_count: got %0d expected 2", s_count); end
        if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", s_ready); end
        if (s_pending !== 4'b0011) begin errors++; $display("[TB] FAIL bp_full_pending: got %b expected 0011", s_pending); end
        if (s_load1 !== 1'b1 || s_in1 !== 8'hA0 || s_load2 !== 1'b1 || s_in2 !== 8'hA1) begin
            errors++; $display("[TB] FAIL bp_full_ports: got %b/%h %b/%h expected 1/a0 1/a1", s_load1, s_in1, s_load2, s_in2);
        end
        s_valid = 2'b11; s_rd0 = 2'd2; s_data0 = 8'hC2; s_rd1 = 2'd3; s_data1 = 8'hC3;
        @(negedge clk);
        checks += 3;
        if (s_count !== 2'd0) begin errors++; $display("[TB] FAIL bp_ignored_count: got %0d expected 0", s_count); end
        if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_again: got %b expected 1", s_ready); end
        if (s_load1 !== 1'b0 || s_pending !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ignored_idle: got load %b pending %b expected 0 0000", s_load1, s_pending); end
        @(negedge clk);
        s_valid = 2'b00;
        checks += 2;
        if (s_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_held_count: got %0d expected 2", s_count); end
        if (s_r1 !== 2'd2 || s_in1 !== 8'hC2 || s_r2 !== 2'd3 || s_in2 !== 8'hC3) begin
            errors++; $display("[TB] FAIL bp_held_ports: got %0d/%h %0d/%h expected 2/c2 3/c3", s_r1, s_in1, s_r2, s_in2);
        end
        @(negedge clk);
        checks++;
        if (s_count !== 2'd0) begin errors++; $display("[TB] FAIL bp_final_count: got %0d expected 0", s_count); end
    endtask

    task automatic test_wrap_order();
        logic [9:0] seen[$];
        logic [7:0] regs[4];
        logic [9:0] want;
        for (int r = 0; r < 4; r++) regs[r] = 8'h00;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rf_load1) seen.push_back({rf_r1, rf_in1});
            if (rf_load2) seen.push_back({rf_r2, rf_in2});
            if (i < 12) drive(2'b01, 2'(i % 4), 8'(i), 2'd0, 8'h00);
            else        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        end
        checks++;
        if (seen.size() != 12) begin errors++; $display("[TB] FAIL wrap_write_count: got %0d expected 12", seen.size()); end
        for (int k = 0; k < 12 && k < seen.size(); k++) begin
            want = {2'(k % 4), 8'(k)};
            checks++;
            if (seen[k] !== want) begin errors++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", k, seen[k], want); end
            regs[seen[k][9:8]] = seen[k][7:0];
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (regs[r] !== 8'(8 + r)) begin errors++; $display("[TB] FAIL wrap_final_reg%0d: got %0d expected %0d", r, regs[r], 8 + r); end
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL wrap_drained: got %0d expected 0", count); end
    endtask

    task automatic test_random();
        logic [9:0] mq[$];
        logic [7:0] exp_regs[4];
        logic [7:0] obs_regs[4];
        logic       e_l1, e_l2, e_ready;
        logic [1:0] e_r1, e_r2;
        logic [7:0] e_d1, e_d2;
        logic [3:0] e_pend;
        logic [1:0] v, r0, r1;
        logic [7:0] d0, d1;
        int         n;
        for (int r = 0; r < 4; r++) begin exp_regs[r] = 8'h00; obs_regs[r] = 8'h00; end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e_l1 = 1'b0; e_r1 = 2'd0; e_d1 = 8'd0;
            e_l2 = 1'b0; e_r2 = 2'd0; e_d2 = 8'd0;
            e_pend = 4'b0000;
            if (mq.size() == 1) begin
                e_l1 = 1'b1; {e_r1, e_d1} = mq[0];
            end else if (mq.size() >= 2) begin
                if (mq[0][9:8] == mq[1][9:8]) begin
                    e_l1 = 1'b1; {e_r1, e_d1} = mq[1];
                end else begin
                    e_l1 = 1'b1; {e_r1, e_d1} = mq[0];
                    e_l2 = 1'b1; {e_r2, e_d2} = mq[1];
                end
            end
            foreach (mq[k]) e_pend[mq[k][9:8]] = 1'b1;
            e_ready = (4 - mq.size()) >= 2;
            checks += 5;
            if ({rf_load1, rf_r1, rf_in1} !== {e_l1, e_r1, e_d1}) begin errors++; $display("[TB] FAIL rand_port1 c%0d: got %b/%0d/%h expected %b/%0d/%h", c, rf_load1, rf_r1, rf_in1, e_l1, e_r1, e_d1); end
            if ({rf_load2, rf_r2, rf_in2} !== {e_l2, e_r2, e_d2}) begin errors++; $display("[TB] FAIL rand_port2 c%0d: got %b/%0d/%h expected %b/%0d/%h", c, rf_load2, rf_r2, rf_in2, e_l2, e_r2, e_d2); end
            if (pending !== e_pend) begin errors++; $display("[TB] FAIL rand_pending c%0d: got %b expected %b", c, pending, e_pend); end
            if (count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, count, mq.size()); end
            if (in_ready !== e_ready) begin errors++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, in_ready, e_ready); end
            if (rf_load1) obs_regs[rf_r1] = rf_in1;
            if (rf_load2) obs_regs[rf_r2] = rf_in2;
            v  = (c < 390) ? 2'($urandom_range(0, 3)) : 2'b00;
            r0 = 2'($urandom_range(0, 3));
            r1 = 2'($urandom_range(0, 3));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            drive(v, r0, d0, r1, d1);
            n = (mq.size() >= 2) ? 2 : mq.size();
            repeat (n) void'(mq.pop_front());
            if (e_ready) begin
                if (v[0]) begin mq.push_back({r0, d0}); exp_regs[r0] = d0; end
                if (v[1]) begin mq.push_back({r1, d1}); exp_regs[r1] = d1; end
            end
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL rand_drained: got %0d expected 0", count); end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (obs_regs[r] !== exp_regs[r]) begin errors++; $display("[TB] FAIL rand_final_reg%0d: got %h expected %h", r, obs_regs[r], exp_regs[r]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
        s_valid = 2'b00; s_rd0 = 2'd0; s_data0 = 8'h00; s_rd1 = 2'd0; s_data1 = 8'h00;
        test_reset();
        test_single_write();
        test_dual_write();
        test_coalesce();
        test_backpressure();
        test_wrap_order();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
